fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of program_counter.
- Reads the current PC and issues single-outstanding reads to the instruction memory/I-cache.
- Buffers returned {pc, instr} pairs in a DEPTH-entry FIFO toward decode.
- Pulses pc_advance_o (wired to program_counter load_plus_four_i) once per accepted fetch. flush_i discards all buffered and in-flight work on redirect.

---
 rtl/fetch_queue_pkg.sv | 35 +++
 rtl/fetch_queue_if.sv | 51 +++++
 rtl/fetch_queue_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared types and constants for the instruction-fetch queue.
//   - rv32i_opcode_t : the control-flow opcodes recognised by predecode
//   - ST_*           : fetch FSM encodings (also visible on state_o)
//   - fetch_entry_t  : {pc, instr, ctrl} record held per FIFO slot
//   - is_ctrl_op()   : true for jal / jalr / branch opcodes
// Optional feature macro: FETCH_PREDECODE_EN (consumed by fetch_queue.sv).
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int FQ_XLEN = 32;

    typedef enum logic [6:0] {
        OP_BR   = 7'b1100011,
        OP_JALR = 7'b1100111,
        OP_JAL  = 7'b1101111
    } rv32i_opcode_t;

    // Fetch FSM encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;  // nothing outstanding
    localparam logic [1:0] ST_REQ  = 2'd1;  // read outstanding, data wanted
    localparam logic [1:0] ST_DROP = 2'd2;  // read outstanding, data discarded

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
        logic               ctrl;
    } fetch_entry_t;

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bus bundle for the fetch queue: the instruction-memory read channel and the
// dequeue channel toward decode. Signal suffixes are from the fetch queue's
// point of view.
//   imem_read_o / imem_addr_o   : read request, held until imem_resp_i
//   imem_resp_i / imem_rdata_i  : read completion and instruction word
//   deq_valid_o / deq_ready_i   : head-entry handshake toward decode
//   deq_pc_o / deq_instr_o / deq_ctrl_o : head entry contents
// Handshakes: a dequeue transfer happens on a rising edge where deq_valid_o
// and deq_ready_i are both 1 (and no flush). A memory read is accepted on the
// edge where imem_resp_i is 1; imem_read_o/imem_addr_o never change before it.
// Modports: master = fetch queue, slave = memory + decode environment.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             imem_read_o;
    logic [WIDTH-1:0] imem_addr_o;
    logic             imem_resp_i;
    logic [WIDTH-1:0] imem_rdata_i;
    logic             deq_valid_o;
    logic             deq_ready_i;
    logic [WIDTH-1:0] deq_pc_o;
    logic [WIDTH-1:0] deq_instr_o;
    logic             deq_ctrl_o;

    modport master (
        output imem_read_o,
        output imem_addr_o,
        input  imem_resp_i,
        input  imem_rdata_i,
        output deq_valid_o,
        input  deq_ready_i,
        output deq_pc_o,
        output deq_instr_o,
        output deq_ctrl_o
    );

    modport slave (
        input  imem_read_o,
        input  imem_addr_o,
        output imem_resp_i,
        output imem_rdata_i,
        input  deq_valid_o,
        output deq_ready_i,
        input  deq_pc_o,
        input  deq_instr_o,
        input  deq_ctrl_o
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular buffer with enqueue, dequeue and synchronous clear.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clear_i       : empty the buffer at the edge; wins over enq_i/deq_i
//   enq_i         : write enq_data_i at the tail
//   enq_data_i    : entry to write
//   deq_i         : retire the head entry
//   head_o        : registered head entry
//   count_o       : occupancy 0..DEPTH
//   full_o/empty_o: occupancy flags
// Callers must not enqueue when full nor dequeue when empty; the fetch
// queue guarantees both through its single-outstanding-read structure.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       enq_i,
    input  logic [DATA_W-1:0]          enq_data_i,
    input  logic                       deq_i,
    output logic [DATA_W-1:0]          head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_i) begin
                mem_q[tail_q] <= enq_data_i;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (deq_i) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({enq_i, deq_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch stage placed after program_counter. Issues one read at a
// time for the current PC, buffers returned {pc, instr[, ctrl]} entries in a
// DEPTH-entry FIFO toward decode, and pulses pc_advance_o when a fetch is
// accepted so the PC steps by four on the same edge. flush_i throws away the
// buffered entries and any read still in flight.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset (0 = reset)
//   pc_i            : current PC
//   pc_advance_o    : one-cycle pulse to program_counter load_plus_four_i
//   flush_i         : redirect; clears the queue, in-flight read is dropped
//   count_o         : FIFO occupancy
//   state_o         : fetch FSM state (ST_IDLE / ST_REQ / ST_DROP)
//   bus             : fetch_queue_if.master (imem read channel, deq channel)
// Optional feature: define FETCH_PREDECODE_EN to tag jal/jalr/branch words
// with ctrl=1 and drive it on deq_ctrl_o; otherwise deq_ctrl_o is 0 and no
// ctrl bit is stored.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       pc_i,
    output logic                   pc_advance_o,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [1:0]             state_o,
    fetch_queue_if.master          bus
);
`ifdef FETCH_PREDECODE_EN
    localparam int ENTRY_W = 2 * WIDTH + 1;
`else
    localparam int ENTRY_W = 2 * WIDTH;
`endif

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   req_pc_q, req_pc_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               deq_fire;
    logic [ENTRY_W-1:0] enq_data;
    logic [ENTRY_W-1:0] head_data;

    // Fetch FSM. A new read is only issued from IDLE with room in the FIFO;
    // because only one read is ever outstanding, occupancy cannot rise while
    // it is in flight, so the response always has a free slot.
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        pc_advance_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush_i && !fifo_full) begin
                    req_pc_d = pc_i;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.imem_resp_i) begin
                    pc_advance_o = !flush_i;
                    state_d      = ST_IDLE;
                end else if (flush_i) begin
                    // The read cannot be withdrawn; remember to ignore it.
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.imem_resp_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign bus.imem_read_o = (state_q != ST_IDLE);
    assign bus.imem_addr_o = req_pc_q;
    assign state_o         = state_q;

    // Flush suppresses the dequeue so decode never consumes a stale head.
    assign deq_fire = !fifo_empty && bus.deq_ready_i && !flush_i;

`ifdef FETCH_PREDECODE_EN
    assign enq_data       = {req_pc_q, bus.imem_rdata_i, is_ctrl_op(bus.imem_rdata_i[6:0])};
    assign bus.deq_ctrl_o = head_data[0];
`else
    assign enq_data       = {req_pc_q, bus.imem_rdata_i};
    assign bus.deq_ctrl_o = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (flush_i),
        .enq_i      (pc_advance_o),
        .enq_data_i (enq_data),
        .deq_i      (deq_fire),
        .head_o     (head_data),
        .count_o    (count_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.deq_valid_o = !fifo_empty;
    assign bus.deq_pc_o    = head_data[ENTRY_W-1 -: WIDTH];
    assign bus.deq_instr_o = head_data[ENTRY_W-WIDTH-1 -: WIDTH];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_PREDECODE_EN
    localparam bit PREDECODE = 1'b1;
`else
    localparam bit PREDECODE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0]          pc_i;
    logic                  pc_advance_o;
    logic                  flush_i;
    logic [$clog2(DEPTH):0] count_o;
    logic [1:0]            state_o;

    fetch_queue_if #(.WIDTH(W)) fq_if ();

    fetch_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_advance_o (pc_advance_o),
        .flush_i      (flush_i),
        .count_o      (count_o),
        .state_o      (state_o),
        .bus          (fq_if)
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] exp_q[$];      // {pc, instr} in delivery order
    logic [W-1:0]   obs_pop[$];    // deq_pc_o values seen at dequeue
    bit             m_busy;        // a read is outstanding
    bit             m_drop;        // outstanding read was flushed
    logic [W-1:0]   m_req_pc;
    logic [W-1:0]   env_pc;        // program_counter model
    logic [W-1:0]   redirect_pc;
    int             wait_cnt;
    int             lat_cur;
    int             lat_knob;      // -1 = random latency 0..3
    bit             rdata_rand;
    logic [W-1:0]   rdata_fixed;
    int             rd_hi;
    int             adv_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ctrl(input logic [W-1:0] w);
        return PREDECODE && (w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111 ||
                             w[6:0] == 7'b1100011);
    endfunction

    function automatic logic [W-1:0] pick_rdata();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0013;
            1:       return 32'h0000_006F;
            2:       return 32'h0000_0067;
            3:       return 32'h0000_0063;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver: one clock cycle ----------------
    // Inputs are applied at the falling edge, outputs checked 1 time unit
    // later, then the model advances to what the next rising edge must do.
    task automatic step(input bit fl, input bit rdy);
        bit           resp;
        bit           adv;
        bit           fire;
        bit           full;
        logic [W-1:0] rd;
        @(negedge clk);
        resp = m_busy && (wait_cnt >= lat_cur);
        rd   = rdata_rand ? pick_rdata() : rdata_fixed;
        flush_i            = fl;
        fq_if.deq_ready_i  = rdy;
        pc_i               = env_pc;
        fq_if.imem_resp_i  = resp;
        fq_if.imem_rdata_i = rd;
        #1;
        adv  = m_busy && !m_drop && resp && !fl;
        fire = (exp_q.size() != 0) && rdy && !fl;
        full = (exp_q.size() >= DEPTH);

        chk("read", 64'(fq_if.imem_read_o), 64'(m_busy));
        if (m_busy) chk("addr", 64'(fq_if.imem_addr_o), 64'(m_req_pc));
        chk("pc_advance", 64'(pc_advance_o), 64'(adv));
        chk("count", 64'(count_o), 64'(exp_q.size()));
        chk("deq_valid", 64'(fq_if.deq_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("deq_pc", 64'(fq_if.deq_pc_o), 64'(exp_q[0][2*W-1:W]));
            chk("deq_instr", 64'(fq_if.deq_instr_o), 64'(exp_q[0][W-1:0]));
            chk("deq_ctrl", 64'(fq_if.deq_ctrl_o), 64'(exp_ctrl(exp_q[0][W-1:0])));
        end
        if (fq_if.imem_read_o) rd_hi++;
        if (pc_advance_o) adv_cnt++;
        if (fire) obs_pop.push_back(fq_if.deq_pc_o);

        // queue contents after the edge
        if (fl) begin
            exp_q.delete();
        end else begin
            if (fire) void'(exp_q.pop_front());
            if (adv) exp_q.push_back({m_req_pc, rd});
        end
        // request tracking
        if (!m_busy) begin
            if (!fl && !full) begin
                m_busy   = 1'b1;
                m_drop   = 1'b0;
                m_req_pc = env_pc;
                wait_cnt = 0;
                lat_cur  = (lat_knob < 0) ? $urandom_range(0, 3) : lat_knob;
            end
        end else if (resp) begin
            m_busy = 1'b0;
        end else begin
            wait_cnt++;
            if (fl) m_drop = 1'b1;
        end
        // program counter
        if (fl) env_pc = redirect_pc;
        else if (adv) env_pc = env_pc + 32'd4;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_req_pc = '0;
        wait_cnt = 0;
        lat_cur  = 0;
        env_pc   = 32'h60;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst                = 1'b0;
        flush_i            = 1'b1;
        pc_i               = '0;
        fq_if.deq_ready_i  = 1'b0;
        fq_if.imem_resp_i  = 1'b0;
        fq_if.imem_rdata_i = '0;
        redirect_pc        = 32'h60;
        lat_knob           = 2;
        rdata_rand         = 1'b0;
        rdata_fixed        = 32'h0000_0013;
        model_reset();

        // reset state
        #12;
        chk("rst_read", 64'(fq_if.imem_read_o), 64'd0);
        chk("rst_addr", 64'(fq_if.imem_addr_o), 64'd0);
        chk("rst_adv", 64'(pc_advance_o), 64'd0);
        chk("rst_valid", 64'(fq_if.deq_valid_o), 64'd0);
        chk("rst_pc", 64'(fq_if.deq_pc_o), 64'd0);
        chk("rst_instr", 64'(fq_if.deq_instr_o), 64'd0);
        chk("rst_ctrl", 64'(fq_if.deq_ctrl_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_state", 64'(state_o), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;

        // single fetch at 0x60, latency 2
        rd_hi = 0; adv_cnt = 0; cyc = 0;
        while (exp_q.size() == 0 && cyc < 50) begin step(1'b0, 1'b0); cyc++; end
        step(1'b0, 1'b0);
        chk("t1_read_cycles", 64'(rd_hi), 64'd3);
        chk("t1_adv_pulses", 64'(adv_cnt), 64'd1);
        chk("t1_valid", 64'(fq_if.deq_valid_o), 64'd1);
        chk("t1_pc", 64'(fq_if.deq_pc_o), 64'h60);
        chk("t1_instr", 64'(fq_if.deq_instr_o), 64'h13);

        // fill to DEPTH with decode stalled
        cyc = 0;
        while (exp_q.size() < DEPTH && cyc < 100) begin step(1'b0, 1'b0); cyc++; end
        repeat (3) step(1'b0, 1'b0);
        chk("t2_count_full", 64'(count_o), 64'(DEPTH));
        chk("t2_state_idle", 64'(state_o), 64'(ST_IDLE));
        chk("t2_no_read", 64'(fq_if.imem_read_o), 64'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t2_reissue_read", 64'(fq_if.imem_read_o), 64'd1);
        chk("t2_reissue_addr", 64'(fq_if.imem_addr_o), 64'h70);

        // flush during REQ, response 3 cycles later, redirect to 0x200
        redirect_pc = 32'h100;
        step(1'b1, 1'b0);
        lat_knob = 3; cyc = 0;
        while (!(m_busy && !m_drop && wait_cnt == 0 && lat_cur == 3) && cyc < 50) begin
            step(1'b0, 1'b0); cyc++;
        end
        redirect_pc = 32'h200;
        step(1'b1, 1'b0);
        adv_cnt = 0; cyc = 0;
        while (m_busy && cyc < 50) begin step(1'b0, 1'b0); cyc++; end
        chk("t3_no_adv", 64'(adv_cnt), 64'd0);
        chk("t3_count", 64'(count_o), 64'd0);
        cyc = 0;
        while (!m_busy && cyc < 50) begin step(1'b0, 1'b0); cyc++; end
        step(1'b0, 1'b0);
        chk("t3_redirect_addr", 64'(fq_if.imem_addr_o), 64'h200);

        // flush coincident with a response and a would-be dequeue
        lat_knob = 2; cyc = 0;
        while (!(exp_q.size() != 0 && m_busy && !m_drop && wait_cnt >= lat_cur) && cyc < 100) begin
            step(1'b0, 1'b0); cyc++;
        end
        adv_cnt = 0;
        redirect_pc = 32'h300;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("t4_no_adv", 64'(adv_cnt), 64'd0);
        chk("t4_count", 64'(count_o), 64'd0);

        // 16 fetches with decode always ready: pointers wrap
        lat_knob = -1;
        redirect_pc = 32'h60;
        step(1'b1, 1'b1);
        obs_pop.delete(); cyc = 0;
        while (obs_pop.size() < 16 && cyc < 400) begin step(1'b0, 1'b1); cyc++; end
        chk("t5_pop_count", 64'(obs_pop.size()), 64'd16);
        for (int i = 0; i < 16 && i < obs_pop.size(); i++) begin
            chk("t5_pop_pc", 64'(obs_pop[i]), 64'(32'h60 + 32'(4 * i)));
        end

        // asynchronous reset in the middle of a read
        cyc = 0;
        while (!(m_busy && exp_q.size() != 0) && cyc < 100) begin step(1'b0, 1'b0); cyc++; end
        step(1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("t6_read_drop", 64'(fq_if.imem_read_o), 64'd0);
        chk("t6_valid_drop", 64'(fq_if.deq_valid_o), 64'd0);
        chk("t6_count", 64'(count_o), 64'd0);
        flush_i = 1'b1;
        fq_if.imem_resp_i = 1'b0;
        fq_if.deq_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // predecode tag
        lat_knob = 1;
        rdata_fixed = 32'h0000_006F;
        cyc = 0;
        while (exp_q.size() == 0 && cyc < 50) begin step(1'b0, 1'b0); cyc++; end
        step(1'b0, 1'b0);
        chk("t7_ctrl_jal", 64'(fq_if.deq_ctrl_o), 64'(PREDECODE));
        rdata_fixed = 32'h0000_0013;
        redirect_pc = 32'h80;
        step(1'b1, 1'b0);
        cyc = 0;
        while (exp_q.size() == 0 && cyc < 50) begin step(1'b0, 1'b0); cyc++; end
        step(1'b0, 1'b0);
        chk("t7_ctrl_addi", 64'(fq_if.deq_ctrl_o), 64'd0);
        chk("t7_valid", 64'(fq_if.deq_valid_o), 64'd1);

        // random traffic
        lat_knob = -1;
        rdata_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit fl;
            fl = ($urandom_range(0, 19) == 0);
            if (fl) redirect_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            step(fl, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
